leaf_xbar_arbiter: RTL
======================

LEAF_XBAR_ARBITER -- requirements
Module: leaf_xbar_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 8: maximum beats per grant before forced release; legal range 2..255.
REQ-002 Parameter GROUP_ID, default 4'b1000: group tag, reported on grp_id output.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 arb_enable  input  1  permits new grants when 1.
REQ-006 req  input  5  per-source request; bit0 = GPU, bits1..4 = spine1..spine4.
REQ-007 last  input  5  per-source end-of-packet flag, qualified by its req bit.
REQ-008 out_ready  input  1  downstream accepts a beat this cycle.
REQ-009 grant  output  5  one-hot grant to crossbar source mux.
REQ-010 current_grant  output  3  encoded grant: 0..4 = source index; 3'b111 = none.
REQ-011 direction  output  2  2'b00 idle, 2'b01 GPU->spine (grant bit0), 2'b10 spine->GPU (grants bits1..4).
REQ-012 busy  output  1  high in XFER state.
REQ-013 beat  output  1  req[g] & out_ready & busy; a beat is transferred this cycle.
REQ-014 forced_release  output  1  one-cycle pulse when MAX_BURST terminates a grant.
REQ-015 grp_id  output  4  constant GROUP_ID.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, XFER and GAP.
REQ-017 IDLE -> XFER: arb_enable=1 and req!=0. The winner SHALL be registered at that edge, so grant is visible one cycle after the request.
REQ-018 The winner SHALL be chosen round-robin: first set req bit at or after rr_ptr, wrapping 4->0; rr_ptr resets to 0.
REQ-019 In XFER, grant, current_grant and direction SHALL hold constant and reflect the registered winner g.
REQ-020 Beat count SHALL be an 8-bit counter: cleared on entry to XFER, incremented on each beat.
REQ-021 XFER -> GAP when any of these holds: (a) a beat occurs with last[g]=1; (b) a beat occurs with beat count = MAX_BURST-1, which also pulses forced_release; (c) req[g]=0, which aborts with no beat.
REQ-022 If (a) and (b) occur in the same cycle, (a) SHALL take priority and forced_release SHALL stay 0.
REQ-023 On leaving XFER, rr_ptr SHALL be set to (g+1) mod 5.
REQ-024 GAP SHALL last exactly one cycle, with grant=0 and current_grant=3'b111, then return to IDLE. This gives the crossbar a turnaround bubble.
REQ-025 If out_ready=0 in XFER, the FSM SHALL hold state and count with no timeout.
REQ-026 If arb_enable falls during XFER, the current grant SHALL complete normally; no new grant is issued from IDLE while arb_enable=0.
REQ-027 Requests from non-granted sources SHALL be ignored until the next IDLE arbitration, with no queuing.
REQ-028 Outside XFER: grant=0, current_grant=3'b111, direction=2'b00, busy=0, beat=0.

Reset
REQ-029 While reset=1 at a clk edge, the block SHALL enter IDLE, clear rr_ptr and beat count, and drive grant=0, current_grant=3'b111, direction=2'b00, busy=0, beat=0 and forced_release=0.
REQ-030 Reset asserted mid-XFER SHALL drop the grant at that edge; no forced_release pulse is generated.

Structure
REQ-031 The shared router package SHALL hold: source index constants (SRC_GPU=0, SRC_SP1..SRC_SP4=1..4), GRANT_NONE=3'b111, DIR_IDLE/DIR_UP/DIR_DOWN encodings, and the FSM state encoding.
REQ-032 The round-robin priority selection SHALL be one combinational sub-module, rr_pick5, with inputs req[4:0] and ptr[2:0] and outputs onehot[4:0], idx[2:0] and any.

Verification
REQ-033 Scenario 1: after reset, req=5'b00001, last=1 on the 3rd beat, out_ready=1 -> grant=00001 one cycle later, direction=01, 3 beats, 1 GAP cycle, rr_ptr=1.
REQ-034 Scenario 2: req=5'b11111 held continuously, each packet 1 beat -> grant order 0,1,2,3,4,0, with one GAP cycle between grants.
REQ-035 Scenario 3: spine2 requests, last never asserted, MAX_BURST=8 -> exactly 8 beats, forced_release pulses on the 8th beat, direction=10.
REQ-036 Scenario 4: out_ready=0 for 20 cycles mid-packet -> grant held, beat count unchanged, no forced_release; transfer resumes when out_ready returns.
REQ-037 Scenario 5: granted source drops req after 2 beats -> GAP the next cycle, forced_release=0, rr_ptr advanced.
REQ-038 Scenario 6: reset asserted mid-XFER; separately, arb_enable=0 with req pending -> grant=0 after the reset edge; no grant issued while arb_enable=0.

Source files
------------

// File: rtl/leaf_xbar_arbiter_pkg.sv
// Shared router definitions for the leaf crossbar arbiter: source indices,
// grant/direction encodings and the arbiter FSM state type.
package leaf_xbar_arbiter_pkg;

    localparam int unsigned NUM_SRC = 5;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned DIR_W   = 2;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned GID_W   = 4;

    localparam logic [IDX_W-1:0] SRC_GPU = 3'd0;
    localparam logic [IDX_W-1:0] SRC_SP1 = 3'd1;
    localparam logic [IDX_W-1:0] SRC_SP2 = 3'd2;
    localparam logic [IDX_W-1:0] SRC_SP3 = 3'd3;
    localparam logic [IDX_W-1:0] SRC_SP4 = 3'd4;

    localparam logic [IDX_W-1:0] GRANT_NONE = 3'b111;

    localparam logic [DIR_W-1:0] DIR_IDLE = 2'b00;
    localparam logic [DIR_W-1:0] DIR_UP   = 2'b01;
    localparam logic [DIR_W-1:0] DIR_DOWN = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    // Round-robin successor, wrapping the last spine back to the GPU.
    function automatic logic [IDX_W-1:0] next_src(input logic [IDX_W-1:0] idx);
        return (idx >= SRC_SP4) ? SRC_GPU : IDX_W'(idx + IDX_W'(1));
    endfunction

endpackage

// File: rtl/leaf_xbar_arbiter_rr_pick5.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping from the last source back to source 0.
module rr_pick5
    import leaf_xbar_arbiter_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    localparam logic [IDX_W:0] NSRC = (IDX_W+1)'(NUM_SRC);

    logic [IDX_W-1:0]     start;
    logic [2*NUM_SRC-1:0] dbl;
    logic [NUM_SRC-1:0]   rot;
    logic [IDX_W-1:0]     off;
    logic [IDX_W:0]       sum;

    // An out-of-range pointer is treated as source 0.
    assign start = (ptr >= IDX_W'(NUM_SRC)) ? '0 : ptr;
    assign dbl   = {req, req};
    assign rot   = dbl[start +: NUM_SRC];

    always_comb begin
        off = '0;
        any = 1'b0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

    assign sum = {1'b0, start} + {1'b0, off};

    always_comb begin
        idx    = GRANT_NONE;
        onehot = '0;
        if (any) begin
            idx    = (sum >= NSRC) ? IDX_W'(sum - NSRC) : IDX_W'(sum);
            onehot = NUM_SRC'(1) << idx;
        end
    end

endmodule

// File: rtl/leaf_xbar_arbiter.sv
// Leaf crossbar arbiter: round-robin grant of one GPU and four spine sources,
// with burst limiting and a one-cycle turnaround gap between grants.
module leaf_xbar_arbiter
    import leaf_xbar_arbiter_pkg::*;
#(
    parameter int unsigned       MAX_BURST = 8,
    parameter logic [GID_W-1:0]  GROUP_ID  = 4'b1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               arb_enable,
    input  logic [NUM_SRC-1:0] req,
    input  logic [NUM_SRC-1:0] last,
    input  logic               out_ready,
    output logic [NUM_SRC-1:0] grant,
    output logic [IDX_W-1:0]   current_grant,
    output logic [DIR_W-1:0]   direction,
    output logic               busy,
    output logic               beat,
    output logic               forced_release,
    output logic [GID_W-1:0]   grp_id
);

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_SRC-1:0] grant_d;
    logic [IDX_W-1:0]   current_grant_d;
    logic [DIR_W-1:0]   direction_d;
    logic               busy_d;

    logic [NUM_SRC-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    logic req_g, last_g, cnt_max, end_pkt;

    rr_pick5 u_pick (
        .req    (req),
        .ptr    (rr_ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // grant is one-hot in XFER and zero elsewhere, so masking selects req[g]/last[g].
    assign req_g   = |(req & grant);
    assign last_g  = |(last & grant);
    assign cnt_max = (cnt_q == CNT_W'(MAX_BURST - 1));

    assign beat           = busy & req_g & out_ready;
    assign end_pkt        = beat & last_g;
    assign forced_release = beat & ~last_g & cnt_max & ~reset;
    assign grp_id         = GROUP_ID;

    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        cnt_d           = cnt_q;
        grant_d         = '0;
        current_grant_d = GRANT_NONE;
        direction_d     = DIR_IDLE;
        busy_d          = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_enable && pick_any) begin
                    state_d         = ST_XFER;
                    cnt_d           = '0;
                    grant_d         = pick_onehot;
                    current_grant_d = pick_idx;
                    direction_d     = (pick_idx == SRC_GPU) ? DIR_UP : DIR_DOWN;
                    busy_d          = 1'b1;
                end
            end
            ST_XFER: begin
                // End-of-packet outranks the burst limit; a dropped request aborts.
                if (!req_g || end_pkt || (beat && cnt_max)) begin
                    state_d  = ST_GAP;
                    rr_ptr_d = next_src(current_grant);
                end else begin
                    if (beat) begin
                        cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                    end
                    grant_d         = grant;
                    current_grant_d = current_grant;
                    direction_d     = direction;
                    busy_d          = 1'b1;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= SRC_GPU;
            cnt_q         <= '0;
            grant         <= '0;
            current_grant <= GRANT_NONE;
            direction     <= DIR_IDLE;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            cnt_q         <= cnt_d;
            grant         <= grant_d;
            current_grant <= current_grant_d;
            direction     <= direction_d;
            busy          <= busy_d;
        end
    end

endmodule
